mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one N:1 data mux between N requesters, with valid/ready handshakes on every side.
- Grants whole bursts, delimited by in_last, to one requester at a time.
- Drives the mux select and feeds the selected data into a registered output slice.
- Sits in front of any shared single-consumer datapath that is fed by several independent producers.

---
 rtl/mux_arb_pkg.sv | 25 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 37 +++
 rtl/mux_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MAX_N = 16;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // OR-reduction encoder; a one-hot (or zero) input yields its bit index.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAX_N; i++) begin
            idx = idx | (oh[i] ? 4'(i) : 4'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    localparam int PW = SEL_W + 1;

    logic [2*N-1:0] req2_s;
    logic [PW-1:0]  pos_s;
    logic [PW-1:0]  wrap_s;

    assign req2_s = {req, req};
    assign found  = |req;
    assign idx    = SEL_W'(onehot_to_idx(MAX_N'(onehot)));

    // Walk from the lowest priority slot down so the nearest hit after ptr is written last.
    always_comb begin
        onehot = '0;
        pos_s  = '0;
        wrap_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos_s  = PW'(ptr) + PW'(k) + PW'(1);
            wrap_s = (pos_s >= PW'(N)) ? (pos_s - PW'(N)) : pos_s;
            onehot = req2_s[pos_s] ? (N'(1) << wrap_s) : onehot;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter sharing one N:1 data mux, with a registered output slice.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = sel_w(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_valid,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [N-1:0]        in_last,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic [N-1:0]        grant,
    output logic [SEL_W-1:0]    sel
);

    state_e              state_q, state_d;
    logic [N-1:0]        grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic                pick_found_s;
    logic [SEL_W-1:0]    pick_idx_s;
    logic [N-1:0]        pick_onehot_s;
    logic                slot_free_s;
    logic                busy_s;
    logic                accept_s;
    logic [DATA_W-1:0]   own_data_s;
    logic                own_last_s;

    rr_pick #(.N(N)) u_pick (
        .req    (in_valid),
        .ptr    (ptr_q),
        .found  (pick_found_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    assign busy_s      = (state_q == ST_BUSY);
    assign slot_free_s = !out_valid_q || out_ready;
    assign accept_s    = busy_s && slot_free_s && |(in_valid & grant_q);

    // Grant-gated AND-OR mux so non-owner inputs, even unknown ones, never reach the slice.
    always_comb begin
        own_data_s = '0;
        own_last_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            own_data_s = own_data_s | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
            own_last_s = own_last_s | (in_last[i] & grant_q[i]);
        end
    end

    // Only the owner sees ready, and only while the output slot can take a beat.
    always_comb begin
        if (busy_s) begin
            in_ready = grant_q & {N{slot_free_s}};
        end else begin
            in_ready = '0;
        end
    end

    // Arbitration FSM and output slice next-state.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_BUSY;
                    grant_d = pick_onehot_s;
                    sel_d   = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = own_data_s;
                    out_last_d  = own_last_s;
                    if (own_last_s) begin
                        state_d = ST_IDLE;
                        ptr_d   = sel_q;
                        grant_d = '0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; ptr resets to N-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            ptr_q       <= SEL_W'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed vector table plus hand-written corner sequences and a random fairness scoreboard.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [7:0]  d [4];

    int n_tests = 0;
    int n_fail  = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel)
    );

    typedef struct {
        logic [3:0] iv;
        logic [3:0] eg;
        logic [1:0] es;
        logic [3:0] er;
        logic       eov;
        logic [7:0] ed;
        logic       el;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] eg, input logic [1:0] es,
                        input logic [3:0] er, input logic eov, input logic [7:0] ed,
                        input logic el);
        @(negedge clk);
        check({tag, ".grant"},     32'(grant),     32'(eg));
        check({tag, ".sel"},       32'(sel),       32'(es));
        check({tag, ".in_ready"},  32'(in_ready),  32'(er));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        check({tag, ".out_data"},  32'(out_data),  32'(ed));
        check({tag, ".out_last"},  32'(out_last),  32'(el));
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev_grant;
    logic [3:0] waiting;
    int         wait_cnt [4];
    int         max_wait;
    int         n_grants;
    int         bad_ready;

    initial begin
        vecs[0]  = '{iv:4'hF, eg:4'h0, es:2'd0, er:4'h0, eov:1'b0, ed:8'h00, el:1'b0};
        vecs[1]  = '{iv:4'hF, eg:4'h1, es:2'd0, er:4'h1, eov:1'b0, ed:8'h00, el:1'b0};
        vecs[2]  = '{iv:4'hF, eg:4'h0, es:2'd0, er:4'h0, eov:1'b1, ed:8'hD0, el:1'b1};
        vecs[3]  = '{iv:4'hF, eg:4'h2, es:2'd1, er:4'h2, eov:1'b0, ed:8'hD0, el:1'b1};
        vecs[4]  = '{iv:4'hF, eg:4'h0, es:2'd1, er:4'h0, eov:1'b1, ed:8'hD1, el:1'b1};
        vecs[5]  = '{iv:4'hF, eg:4'h4, es:2'd2, er:4'h4, eov:1'b0, ed:8'hD1, el:1'b1};
        vecs[6]  = '{iv:4'hF, eg:4'h0, es:2'd2, er:4'h0, eov:1'b1, ed:8'hD2, el:1'b1};
        vecs[7]  = '{iv:4'hF, eg:4'h8, es:2'd3, er:4'h8, eov:1'b0, ed:8'hD2, el:1'b1};
        vecs[8]  = '{iv:4'hF, eg:4'h0, es:2'd3, er:4'h0, eov:1'b1, ed:8'hD3, el:1'b1};
        vecs[9]  = '{iv:4'hF, eg:4'h1, es:2'd0, er:4'h1, eov:1'b0, ed:8'hD3, el:1'b1};
        vecs[10] = '{iv:4'h0, eg:4'h0, es:2'd0, er:4'h0, eov:1'b1, ed:8'hD0, el:1'b1};
        vecs[11] = '{iv:4'h0, eg:4'h0, es:2'd0, er:4'h0, eov:1'b0, ed:8'hD0, el:1'b1};

        rst_n = 1'b0;
        in_valid = 4'h0;
        in_last = 4'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        @(negedge clk);
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.out_valid", 32'(out_valid), 32'h0);
        check("rst.sel", 32'(sel), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Rotation: every requester valid, single-beat bursts.
        for (int i = 0; i < 4; i++) d[i] = 8'hD0 + 8'(i);
        in_last = 4'hF;
        for (int v = 0; v < 12; v++) begin
            in_valid = vecs[v].iv;
            step($sformatf("rot%0d", v), vecs[v].eg, vecs[v].es, vecs[v].er,
                 vecs[v].eov, vecs[v].ed, vecs[v].el);
        end

        // Burst lock: requester 1 holds the mux for three beats while 2 waits.
        in_valid = 4'b0110; in_last = 4'b0100; d[1] = 8'hA1; d[2] = 8'hB0;
        step("lock0", 4'h0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b1);
        in_last = 4'b0100;
        step("lock1", 4'h2, 2'd1, 4'h2, 1'b0, 8'hD0, 1'b1);
        d[1] = 8'hA2;
        step("lock2", 4'h2, 2'd1, 4'h2, 1'b1, 8'hA1, 1'b0);
        d[1] = 8'hA3; in_last = 4'b0110;
        step("lock3", 4'h2, 2'd1, 4'h2, 1'b1, 8'hA2, 1'b0);
        in_valid = 4'b0100;
        step("lock4", 4'h0, 2'd1, 4'h0, 1'b1, 8'hA3, 1'b1);
        step("lock5", 4'h4, 2'd2, 4'h4, 1'b0, 8'hA3, 1'b1);
        in_valid = 4'h0; in_last = 4'h0;
        step("lock6", 4'h0, 2'd2, 4'h0, 1'b1, 8'hB0, 1'b1);

        // Backpressure: four cycles of out_ready low mid-burst.
        in_valid = 4'b1000; d[3] = 8'hC1;
        step("bp0", 4'h0, 2'd2, 4'h0, 1'b0, 8'hB0, 1'b1);
        step("bp1", 4'h8, 2'd3, 4'h8, 1'b0, 8'hB0, 1'b1);
        d[3] = 8'hC2; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step($sformatf("bp_hold%0d", c), 4'h8, 2'd3, 4'h0, 1'b1, 8'hC1, 1'b0);
        end
        out_ready = 1'b1;
        step("bp6", 4'h8, 2'd3, 4'h8, 1'b1, 8'hC1, 1'b0);
        d[3] = 8'hC3;
        step("bp7", 4'h8, 2'd3, 4'h8, 1'b1, 8'hC2, 1'b0);
        d[3] = 8'hC4; in_last = 4'b1000;
        step("bp8", 4'h8, 2'd3, 4'h8, 1'b1, 8'hC3, 1'b0);
        in_valid = 4'h0; in_last = 4'h0;
        step("bp9", 4'h0, 2'd3, 4'h0, 1'b1, 8'hC4, 1'b1);
        step("bp10", 4'h0, 2'd3, 4'h0, 1'b0, 8'hC4, 1'b1);

        // Owner stall: requester 0 drops valid for three cycles while others request.
        in_valid = 4'b0001; d[0] = 8'hE1;
        step("st0", 4'h0, 2'd3, 4'h0, 1'b0, 8'hC4, 1'b1);
        step("st1", 4'h1, 2'd0, 4'h1, 1'b0, 8'hC4, 1'b1);
        in_valid = 4'b1110;
        step("st2", 4'h1, 2'd0, 4'h1, 1'b1, 8'hE1, 1'b0);
        step("st3", 4'h1, 2'd0, 4'h1, 1'b0, 8'hE1, 1'b0);
        step("st4", 4'h1, 2'd0, 4'h1, 1'b0, 8'hE1, 1'b0);
        in_valid = 4'b1111; in_last = 4'b0001; d[0] = 8'hE2;
        step("st5", 4'h1, 2'd0, 4'h1, 1'b0, 8'hE1, 1'b0);
        in_valid = 4'b1110;
        step("st6", 4'h0, 2'd0, 4'h0, 1'b1, 8'hE2, 1'b1);
        d[1] = 8'hF1; in_last = 4'h0;
        step("st7", 4'h2, 2'd1, 4'h2, 1'b0, 8'hE2, 1'b1);
        d[1] = 8'hF2;
        step("st8", 4'h2, 2'd1, 4'h2, 1'b1, 8'hF1, 1'b0);

        // Asynchronous reset mid-burst takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'h0);
        check("arst.grant", 32'(grant), 32'h0);
        check("arst.sel", 32'(sel), 32'h0);
        check("arst.in_ready", 32'(in_ready), 32'h0);
        check("arst.out_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 4'b1001; in_last = 4'b1001; d[0] = 8'h10; d[3] = 8'h13;
        step("tie0", 4'h0, 2'd0, 4'h0, 1'b0, 8'h00, 1'b0);
        step("tie1", 4'h1, 2'd0, 4'h1, 1'b0, 8'h00, 1'b0);

        // Random fairness run.
        prev_grant = grant;
        waiting = 4'h0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        max_wait = 0;
        n_grants = 0;
        bad_ready = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i]) in_valid[i] = ($urandom_range(0, 15) != 0);
                else             in_valid[i] = ($urandom_range(0, 3) == 0);
                in_last[i] = ($urandom_range(0, 2) == 0);
                d[i] = 8'($urandom_range(0, 255));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_grant == 4'h0 && grant != 4'h0) begin
                n_grants++;
                for (int i = 0; i < 4; i++) begin
                    if (grant[i]) begin
                        if (waiting[i] && wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                        waiting[i] = 1'b0;
                        wait_cnt[i] = 0;
                    end else if (waiting[i]) begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] || grant[i]) begin
                    waiting[i] = 1'b0;
                    wait_cnt[i] = 0;
                end else if (!waiting[i]) begin
                    waiting[i] = 1'b1;
                    wait_cnt[i] = 0;
                end
            end
            if ((in_ready & ~grant) != 4'h0 || $countones(in_ready) > 1) bad_ready++;
            prev_grant = grant;
            @(posedge clk);
            #1;
        end
        check("rand.max_wait_le_3", 32'(max_wait > 3), 32'h0);
        check("rand.in_ready_ok", 32'(bad_ready), 32'h0);
        check("rand.grants_seen", 32'(n_grants > 500), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
